// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the analog-mux scan controller.
package mux_scan_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } state_e;

  // Mux select encoding {s1,s2} for each channel.
  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  // Default width of the settle-count input.
  localparam int SETTLE_W_DEF = 4;

  // Map a channel index onto the mux select code.
  function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
    logic [1:0] sel;
    case (ch)
      2'd0:    sel = CH0;
      2'd1:    sel = CH1;
      2'd2:    sel = CH2;
      default: sel = CH3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Dwell counter: loaded with max(count,1)-1, expired when it reaches zero.
// A load of N therefore gives exactly max(N,1) enabled cycles; the counter
// saturates at zero and never wraps.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] count,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next-count: load takes priority, otherwise count down to zero and stop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (count == '0) ? '0 : count - W'(1);
    end else if (enable && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four inputs of an external 4:1 mux: for each channel it drives
// the select, dwells for the settle time, samples d, and after channel 3
// publishes the sampled word and a mismatch flag against the expected word.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int NCH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [3:0]          expected,
  input  logic                d,
  output logic                s1,
  output logic                s2,
  output logic                busy,
  output logic                done,
  output logic [3:0]          result,
  output logic                mismatch
);

  localparam logic [1:0] LAST_CH = 2'(NCH - 1);

  state_e              state_q, state_d;
  logic [1:0]          ch_q, ch_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          shadow_q, shadow_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [3:0]          expected_q, expected_d;
  logic [3:0]          result_q, result_d;
  logic                mismatch_q, mismatch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic                tmr_enable;
  logic [SETTLE_W-1:0] tmr_count;
  logic                tmr_expired;

  // At start the timer must see the live settle input, since settle_q is
  // only being captured on that same edge; later channels use the latched copy.
  assign tmr_count = (state_q == IDLE) ? settle : settle_q;

  settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .count   (tmr_count),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    settle_d   = settle_q;
    expected_d = expected_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          settle_d   = settle;
          expected_d = expected;
          ch_d       = 2'd0;
          sel_d      = ch_to_sel(2'd0);
          shadow_d   = '0;
          tmr_load   = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        tmr_enable = 1'b1;
        if (tmr_expired) state_d = SAMPLE;
      end

      SAMPLE: begin
        shadow_d[ch_q] = d;
        if (ch_q == LAST_CH) begin
          // Publish on this edge so result/mismatch are already valid in DONE.
          result_d   = shadow_d;
          mismatch_d = |(shadow_d ^ expected_q);
          state_d    = DONE;
        end else begin
          ch_d     = ch_q + 2'd1;
          sel_d    = ch_to_sel(ch_q + 2'd1);
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end

      DONE: begin
        // start is deliberately ignored here; a new scan begins only from IDLE.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow and latched operands are reset too, so an aborted scan leaves nothing behind.
      state_q    <= IDLE;
      ch_q       <= '0;
      sel_q      <= CH0;
      shadow_q   <= '0;
      settle_q   <= '0;
      expected_q <= '0;
      result_q   <= '0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sel_q      <= sel_d;
      shadow_q   <= shadow_d;
      settle_q   <= settle_d;
      expected_q <= expected_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s1       = sel_q[1];
  assign s2       = sel_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mismatch = mismatch_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter SETTLE_W, default 4: SHALL set the width of the settle-count input.
REQ-003 Parameter NCH, default 4: SHALL fix the number of scanned channels at 4; any other value is unsupported.
REQ-004 clk  in  1  SHALL be the single rising-edge clock.
REQ-005 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-006 start  in  1  SHALL request one scan of all four mux inputs; it is sampled only in IDLE.
REQ-007 settle  in  SETTLE_W  SHALL give the dwell cycles per channel before sampling; it is latched at start.
REQ-008 expected  in  4  SHALL give the expected value per channel (bit n = channel n); it is latched at start.
REQ-009 d  in  1  SHALL be the selected data from the downstream 4:1 mux.
REQ-010 s1  out  1  SHALL be the mux select MSB.
REQ-011 s2  out  1  SHALL be the mux select LSB.
REQ-012 busy  out  1  SHALL be high while a scan is in progress (all states except IDLE).
REQ-013 done  out  1  SHALL be a one-cycle pulse when the scan completes.
REQ-014 result  out  4  SHALL hold the sampled d for channels 3..0.
REQ-015 mismatch  out  1  SHALL equal the OR-reduction of result XOR latched expected, and SHALL be valid from done onward.

Function
REQ-016 The select encoding SHALL be {s1,s2}: ch0=00, ch1=01, ch2=10, ch3=11.
REQ-017 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and DONE.
REQ-018 In IDLE with start=1, the FSM SHALL latch settle and expected, set ch=0, clear the shadow register, and go to SETTLE.
REQ-019 SETTLE SHALL last max(settle,1) cycles with {s1,s2}=ch, then go to SAMPLE.
REQ-020 SAMPLE SHALL last 1 cycle; at its closing edge d is written to shadow[ch].
- If ch=3, the FSM SHALL go to DONE.
- Otherwise ch SHALL increment and the FSM SHALL go to SETTLE.
REQ-021 DONE SHALL last 1 cycle.
- done=1 during this cycle.
- result and mismatch SHALL be loaded from shadow at the closing edge of the SAMPLE cycle for ch3, so they are valid in the DONE cycle.
- The FSM SHALL return to IDLE.
REQ-022 Latency: with start accepted at edge 0 and S=max(settle,1), done SHALL be high in cycle 4(S+1)+1.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new scan SHALL be accepted only from IDLE.
REQ-025 result and mismatch SHALL hold their values until the next DONE, and SHALL not change while busy.
REQ-026 {s1,s2} SHALL hold the last channel value in DONE and IDLE, and SHALL switch only at SETTLE entry.
REQ-027 A change of settle or expected while busy SHALL not affect the scan in progress.
REQ-028 The settle counter SHALL not wrap: settle at its maximum value (2^SETTLE_W-1) SHALL give exactly that many cycles.

Reset
REQ-029 While rst_n=0, the block SHALL hold the state IDLE, with outputs as follows.
- s1=0, s2=0, busy=0, done=0, result=0, mismatch=0.
- ch, shadow, and latched settle/expected all 0.
REQ-030 Reset mid-scan SHALL abort the scan immediately without asserting done.
REQ-031 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-032 Package mux_scan_pkg SHALL hold the FSM state typedef, the select-encoding constants CH0..CH3, and the default SETTLE_W.
REQ-033 The dwell counter SHALL be a sub-module settle_timer with inputs load, count and enable, and output expired.
REQ-034 The 4:1 mux SHALL stay external; this block SHALL only drive s1/s2 and consume d.

Verification
REQ-035 Scan 1: reset; settle=2; d from a mux model with i=4'b0001; start -> done in cycle 13, result=4'b0001, mismatch=0 against expected=4'b0001.
REQ-036 Walking-one: i=0010, then 0100, then 1000, with expected equal to i each time -> result=i and mismatch=0 each time; {s1,s2} sequence 00,01,10,11 checked every scan.
REQ-037 Settle boundaries: settle=0 with i=4'b1010, expected=4'b1010 -> done in cycle 9, result=1010; settle=15 -> done in cycle 65.
REQ-038 Mismatch: i=4'b0110, expected=4'b0111 -> result=0110, mismatch=1; start pulsed during busy produces no extra done.
REQ-039 Reset mid-scan: assert rst_n=0 during ch2 SETTLE -> outputs all 0 at once, no done; a fresh scan with i=4'b1111 then gives result=1111.
